// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared constants and types for the conv layer 3 scheduler slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int bitwidth  = 16;
  localparam int N_KERNEL  = 10;
  localparam int N_CHANNEL = 2;
  localparam int KW        = 4;
  localparam int CW        = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  typedef logic signed [bitwidth-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/conv_mac_acc.sv
// ============================================================================
// Module : conv_mac_acc
// Brief  : N_KERNEL-entry accumulator bank; write on channel 0, add on later channels.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module conv_mac_acc
  import conv_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         add,
  input  logic [KW-1:0]                idx,
  input  logic [bitwidth-1:0]          data,
  output logic [bitwidth*N_KERNEL-1:0] acc_flat
);

  generate
    for (genvar k = 0; k < N_KERNEL; k++) begin : g_entry
      data_t r_acc;
      data_t w_sum;

      // Plain two's-complement wrap, identical to the combinational layer.
      assign w_sum = r_acc + data_t'(data);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (wr_en && (idx == KW'(k))) begin
          r_acc <= add ? w_sum : data_t'(data);
        end
      end

      assign acc_flat[k*bitwidth +: bitwidth] = r_acc;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/conv_layer_3_scheduler.sv
// ============================================================================
// Module : conv_layer_3_scheduler
// Brief  : Sequences one shared convolution_point over all kernel/channel pairs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module conv_layer_3_scheduler
  import conv_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic [KW-1:0]                sel_kernel,
  output logic [CW-1:0]                sel_channel,
  input  logic [bitwidth-1:0]          point_result,
  output logic [bitwidth*N_KERNEL-1:0] featuremap3,
  output logic                         out_valid,
  input  logic                         out_ready
);

  sched_state_t state, state_next;
  logic [KW-1:0] k_cnt;
  logic [CW-1:0] c_cnt;
  logic          last_pass;
  logic          in_run;

  assign in_run    = (state == RUN);
  assign last_pass = in_run && (k_cnt == KW'(N_KERNEL-1)) && (c_cnt == CW'(N_CHANNEL-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_cnt <= '0;
      c_cnt <= '0;
    end else begin
      state <= state_next;
      // Channel is the fast index; both counters return to 0 on leaving RUN.
      if (in_run) begin
        if (c_cnt == CW'(N_CHANNEL-1)) begin
          c_cnt <= '0;
          k_cnt <= (k_cnt == KW'(N_KERNEL-1)) ? '0 : k_cnt + KW'(1);
        end else begin
          c_cnt <= c_cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    out_valid   = 1'b0;
    sel_kernel  = '0;
    sel_channel = '0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy        = 1'b1;
        sel_kernel  = k_cnt;
        sel_channel = c_cnt;
        if (last_pass) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  conv_mac_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_run),
    .add      (c_cnt != '0),
    .idx      (k_cnt),
    .data     (point_result),
    .acc_flat (featuremap3)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_3_scheduler.sv
// ============================================================================
// Module : tb_conv_layer_3_scheduler
// Brief  : Directed self-checking bench with a behavioural convolution_point model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_conv_layer_3_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic [3:0]   sel_kernel;
  logic [0:0]   sel_channel;
  logic [15:0]  point_result;
  logic [159:0] featuremap3;
  logic         out_valid;
  logic         out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;
  int pr_i;

  conv_layer_3_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .sel_kernel   (sel_kernel),
    .sel_channel  (sel_channel),
    .point_result (point_result),
    .featuremap3  (featuremap3),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared convolution_point.
  always_comb begin
    pr_i = 10 * int'(sel_kernel) + int'(sel_channel);
    if (mode == 1 && sel_kernel == 4'd3) pr_i = 32'h7FFF;
    if (mode == 1 && sel_kernel == 4'd5) pr_i = (sel_channel == 1'b1) ? -7 : -5;
    if (mode == 2) pr_i = 100 + 3 * int'(sel_kernel) - int'(sel_channel);
    point_result = pr_i[15:0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; mode = 0;
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_init_flags busy=%b out_valid=%b required 0/0", busy, out_valid); end
    rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    n_cmp++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL reset_pre_busy busy=%b required 1", busy); end
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_mid_flags busy=%b out_valid=%b required 0/0", busy, out_valid); end
    n_cmp++; if (sel_kernel !== 4'd0 || sel_channel !== 1'b0) begin n_err++;
      $display("FAIL reset_mid_sel k=%0d c=%0d required 0/0", sel_kernel, sel_channel); end
    for (int k = 0; k < 10; k++) begin
      got = featuremap3[k*16 +: 16];
      n_cmp++; if (got !== 16'd0) begin n_err++;
        $display("FAIL reset_fm[%0d] got=%h required 0000", k, got); end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    logic [15:0] got;
    mode = 0; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (sel_kernel !== 4'(i / 2) || sel_channel !== 1'(i % 2)) begin n_err++;
        $display("FAIL nom_sel[%0d] k=%0d c=%0d required %0d/%0d", i, sel_kernel, sel_channel, i / 2, i % 2); end
      n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++;
        $display("FAIL nom_run_flags[%0d] busy=%b out_valid=%b required 1/0", i, busy, out_valid); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL nom_done_flags out_valid=%b busy=%b required 1/0", out_valid, busy); end
    n_cmp++; if (sel_kernel !== 4'd0 || sel_channel !== 1'b0) begin n_err++;
      $display("FAIL nom_hold_sel k=%0d c=%0d required 0/0", sel_kernel, sel_channel); end
    for (int k = 0; k < 10; k++) begin
      got = featuremap3[k*16 +: 16];
      n_cmp++; if (got !== 16'(20 * k + 1)) begin n_err++;
        $display("FAIL nom_fm[%0d] got=%0d required %0d", k, got, 20 * k + 1); end
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL nom_handshake out_valid=%b busy=%b required 0/0", out_valid, busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    logic [15:0] exp;
    mode = 1; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++;
      $display("FAIL wrap_done out_valid=%b required 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      got = featuremap3[k*16 +: 16];
      exp = (k == 3) ? 16'hFFFE : (k == 5) ? 16'hFFF4 : 16'(20 * k + 1);
      n_cmp++; if (got !== exp) begin n_err++;
        $display("FAIL wrap_fm[%0d] got=%h required %h", k, got, exp); end
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    mode = 0;
  endtask

  task automatic test_backpressure();
    mode = 0; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_err++;
        $display("FAIL bp_flags[%0d] out_valid=%b busy=%b required 1/0", i, out_valid, busy); end
      n_cmp++; if (featuremap3[0 +: 16] !== 16'd1 || featuremap3[144 +: 16] !== 16'd181) begin n_err++;
        $display("FAIL bp_fm[%0d] fm0=%0d fm9=%0d required 1/181", i, featuremap3[0 +: 16], featuremap3[144 +: 16]); end
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_release out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_ignored_start();
    logic [15:0] got;
    mode = 0; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (sel_kernel !== 4'(i / 2) || sel_channel !== 1'(i % 2) || busy !== 1'b1) begin n_err++;
        $display("FAIL ign_sel[%0d] k=%0d c=%0d busy=%b required %0d/%0d/1", i, sel_kernel, sel_channel, busy, i / 2, i % 2); end
      start = (i == 5);
      step();
    end
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++;
      $display("FAIL ign_done out_valid=%b required 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      got = featuremap3[k*16 +: 16];
      n_cmp++; if (got !== 16'(20 * k + 1)) begin n_err++;
        $display("FAIL ign_fm[%0d] got=%0d required %0d", k, got, 20 * k + 1); end
    end
    start = 1'b1; out_ready = 1'b1; step(); start = 1'b0; out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL ign_hs_start busy=%b out_valid=%b required 0/0", busy, out_valid); end
    step();
    n_cmp++; if (busy !== 1'b0 || sel_kernel !== 4'd0 || sel_channel !== 1'b0) begin n_err++;
      $display("FAIL ign_idle busy=%b k=%0d c=%0d required 0/0/0", busy, sel_kernel, sel_channel); end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    mode = 1; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
    rst = 1'b1; step();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || sel_kernel !== 4'd0) begin n_err++;
      $display("FAIL abort_flags busy=%b out_valid=%b k=%0d required 0/0/0", busy, out_valid, sel_kernel); end
    n_cmp++; if (featuremap3 !== 160'd0) begin n_err++;
      $display("FAIL abort_fm_clear got=%h required 0", featuremap3); end
    rst = 1'b0; mode = 2;
    step();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (sel_kernel !== 4'(i / 2) || sel_channel !== 1'(i % 2)) begin n_err++;
        $display("FAIL abort_sel[%0d] k=%0d c=%0d required %0d/%0d", i, sel_kernel, sel_channel, i / 2, i % 2); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++;
      $display("FAIL abort_done out_valid=%b required 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      got = featuremap3[k*16 +: 16];
      n_cmp++; if (got !== 16'(199 + 6 * k)) begin n_err++;
        $display("FAIL abort_fm[%0d] got=%0d required %0d", k, got, 199 + 6 * k); end
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
